wasm_frame_ctrl: RTL and testbench
==================================

Name: wasm_frame_ctrl

Overview:
- Initiator/master for the SuperStack command port. Executes WebAssembly call-frame commands (call, return, local.get, local.set, local.tee) as sequences of single-cycle stack ops.
- Owns the frame base, the underflow limit and a private frame-record stack. Sits between the instruction decoder and SuperStack.

Parameters:
- WIDTH, 8, data width; must match SuperStack.
- DEPTH, 3, SuperStack depth exponent; MAX_STACK = 2^(DEPTH+1)-1.
- FRAMES, 8, max nested call depth (frame records held).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE with no response pending
- cmd_op  in  3  0 NOP, 1 CALL, 2 RETURN, 3 LOCAL_GET, 4 LOCAL_SET, 5 LOCAL_TEE
- cmd_arg  in  DEPTH+1  nargs (CALL) / nresults (RETURN) / local idx
- cmd_nlocals  in  DEPTH+1  extra zeroed locals (CALL only)
- rsp_valid  out  1  response valid; held until rsp_ready
- rsp_ready  in  1  response accept
- rsp_data  out  WIDTH  local value (LOCAL_GET), else 0
- rsp_error  out  3  0 OK, 1 underflow, 2 overflow, 3 bad local idx, 4 frame overflow, 5 frame underflow, 6 bad arity
- st_op  out  3  0 NONE, 1 PUSH, 2 POP, 3 REPLACE, 4 INDEX_RESET, 5 INDEX_RESET_AND_PUSH, 6 UNDERFLOW_GET, 7 UNDERFLOW_SET
- st_data, st_offset, st_lower_limit, st_upper_limit  out  WIDTH/DEPTH+1  stack op operands
- st_underflow_limit  out  DEPTH+1  equals cur_limit at all times
- st_dropTos  out  1  drop ToS on UNDERFLOW_SET
- st_index  in  DEPTH+1  stack index
- st_out  in  WIDTH  stack ToS
- st_getter  in  WIDTH  getter result
- st_error  in  2  0 NONE, 1 UNDERFLOW, 2 OVERFLOW, 3 BAD_OFFSET

Behaviour:
- Reset: cur_base=0, cur_limit=0, frame_depth=0, FSM=IDLE, st_op=NONE, st_dropTos=0, rsp_valid=0, rsp_data=0, rsp_error=0, cmd_ready=1. Reset mid-command aborts it immediately; no response is issued.
- Accept on cmd_valid&&cmd_ready in cycle T. The pre-check (below) is evaluated in T against st_index.
- Each stack op takes 2 cycles:
  - issue cycle: st_op driven, operands valid.
  - check cycle: st_op=NONE, st_error and st_getter sampled.
- If st_error!=0 in any check cycle: abort, rsp_error=st_error (1/2/3 map directly), frame state unchanged.
- A pre-check failure produces a response in T+1 with no stack ops issued.
- NOP: rsp OK at T+1.
- CALL(n,l):
  - Pre-check, in order:
    - frame_depth==FRAMES -> 4.
    - n > st_index-cur_limit -> 6.
    - st_index+l > MAX_STACK -> 2.
  - Issues l PUSH ops with data 0.
  - Then: push record {cur_base,cur_limit}; cur_base=st_index-n; cur_limit=cur_base+n+l. These updates land in the response cycle.
  - rsp at T+1+2l.
- RETURN(n):
  - Pre-check: frame_depth==0 -> 5; n > st_index-cur_limit -> 6.
  - Copy loop, i=0..n-1 ascending:
    - UNDERFLOW_GET with lower=st_index-n, upper=st_index, offset=i.
    - UNDERFLOW_SET with data=getter, lower=cur_base, upper=st_index, offset=i, dropTos=0.
  - Ascending order is safe because the destination never exceeds the source.
  - Then INDEX_RESET with offset=cur_base+n. Pop record into cur_base/cur_limit.
  - rsp at T+1+4n+2.
- LOCAL_GET(i):
  - Pre-check: i >= cur_limit-cur_base -> 3.
  - UNDERFLOW_GET with lower=cur_base, upper=cur_limit, offset=i; then PUSH getter.
  - rsp_data=getter; rsp at T+5.
  - Pre-check: st_index==MAX_STACK -> 2.
- LOCAL_SET(i) / LOCAL_TEE(i):
  - Pre-check: idx check as LOCAL_GET; st_index==cur_limit -> 1.
  - Single UNDERFLOW_SET with data=st_out, lower=cur_base, upper=cur_limit, dropTos=1 (SET) / 0 (TEE).
  - rsp at T+3.
- All offset arithmetic is DEPTH+1 bits, unsigned. Pre-checks guarantee no wrap.
- rsp_valid holds its data stable until rsp_ready. cmd_ready=0 while busy or while a response is pending.

Test Plan:
- Reset, then LOCAL_GET 0 with empty frame -> rsp_error=3 at T+1, no st_op issued.
- Stack=[5,6] (index 2), CALL n=2 l=1 -> one PUSH 0; index 3, cur_base=0, st_underflow_limit=3, rsp OK at T+3.
- After that, LOCAL_GET 1 -> rsp_data=6, index 4; then LOCAL_SET 2 -> slot2=6, index 3, rsp at T+3.
- Push 9 then RETURN 1 -> slot0=9, index 1, cur_base/limit restored to 0/0, rsp at T+7.
- Nest FRAMES+1 CALLs with n=0 l=0 -> last rsp_error=4; RETURN at depth 0 -> rsp_error=5.
- Hold rsp_ready=0 five cycles after LOCAL_GET -> rsp_valid/rsp_data stable, cmd_ready=0. Assert reset mid-RETURN copy -> FSM IDLE, frame_depth=0 next cycle.

Source files
------------

// File: rtl/wasm_frame_ctrl.sv
// wasm_frame_ctrl: WebAssembly call-frame sequencer driving the SuperStack
// command port as a series of two-cycle stack ops (issue, then check).
// Ports: cmd_* command in (valid/ready), rsp_* response out (held until
// rsp_ready), st_* SuperStack op/operands out, st_index/out/getter/error in.
module wasm_frame_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 3,
  parameter int FRAMES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [DEPTH:0]   cmd_arg,
  input  logic [DEPTH:0]   cmd_nlocals,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_error,
  output logic [2:0]       st_op,
  output logic [WIDTH-1:0] st_data,
  output logic [DEPTH:0]   st_offset,
  output logic [DEPTH:0]   st_lower_limit,
  output logic [DEPTH:0]   st_upper_limit,
  output logic [DEPTH:0]   st_underflow_limit,
  output logic             st_dropTos,
  input  logic [DEPTH:0]   st_index,
  input  logic [WIDTH-1:0] st_out,
  input  logic [WIDTH-1:0] st_getter,
  input  logic [1:0]       st_error
);

  localparam int AW = DEPTH + 1;
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FRAMES + 1);
  localparam int RW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam logic [AW-1:0] MAX_STACK = '1;

  localparam logic [2:0] OP_CALL = 3'd1;
  localparam logic [2:0] OP_RET  = 3'd2;
  localparam logic [2:0] OP_LGET = 3'd3;
  localparam logic [2:0] OP_LSET = 3'd4;
  localparam logic [2:0] OP_LTEE = 3'd5;

  localparam logic [2:0] ST_NONE = 3'd0;
  localparam logic [2:0] ST_PUSH = 3'd1;
  localparam logic [2:0] ST_IRST = 3'd4;
  localparam logic [2:0] ST_UGET = 3'd6;
  localparam logic [2:0] ST_USET = 3'd7;

  localparam logic [2:0] E_OK   = 3'd0;
  localparam logic [2:0] E_UND  = 3'd1;
  localparam logic [2:0] E_OVF  = 3'd2;
  localparam logic [2:0] E_IDX  = 3'd3;
  localparam logic [2:0] E_FOVF = 3'd4;
  localparam logic [2:0] E_FUND = 3'd5;
  localparam logic [2:0] E_AR   = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_CHECK, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     base_q, base_d;
  logic [AW-1:0]     limit_q, limit_d;
  logic [FW-1:0]     depth_q, depth_d;
  logic [2:0]        op_q, op_d;
  logic [AW-1:0]     arg_q, arg_d;
  logic [AW-1:0]     nl_q, nl_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     last_q, last_d;
  logic [WIDTH-1:0]  getter_q, getter_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic [2:0]        rerr_q, rerr_d;
  logic [2*AW-1:0]   rec_q [FRAMES];

  logic              push_rec, commit;
  logic [RW-1:0]     wr_ptr, rd_ptr;
  logic [AW-1:0]     avail, nloc;
  logic [2:0]        pre_err;
  logic [CW-1:0]     pre_nops;
  logic [2:0]        c_op;
  logic [AW-1:0]     c_idx, c_n, c_l;
  logic              is_last, d_call, d_lset;
  logic              d_ret_get, d_ret_set, d_ret_ir;
  logic              d_lg_get, d_lg_push, dec_get;
  logic [AW-1:0]     half;

  assign wr_ptr = RW'(depth_q);
  assign rd_ptr = RW'(depth_q - 1'b1);
  assign avail  = st_index - limit_q;
  assign nloc   = limit_q - base_q;

  // Zero-op commands commit straight from IDLE using the live command.
  assign c_op  = (state_q == S_IDLE) ? cmd_op : op_q;
  assign c_idx = (state_q == S_IDLE) ? st_index : idx_q;
  assign c_n   = (state_q == S_IDLE) ? cmd_arg : arg_q;
  assign c_l   = (state_q == S_IDLE) ? cmd_nlocals : nl_q;

  // RETURN runs GET/SET pairs on even/odd steps, INDEX_RESET last.
  assign is_last   = (cnt_q == last_q);
  assign half      = cnt_q[AW:1];
  assign d_call    = (op_q == OP_CALL);
  assign d_ret_get = (op_q == OP_RET) && !is_last && !cnt_q[0];
  assign d_ret_set = (op_q == OP_RET) && !is_last && cnt_q[0];
  assign d_ret_ir  = (op_q == OP_RET) && is_last;
  assign d_lg_get  = (op_q == OP_LGET) && (cnt_q == '0);
  assign d_lg_push = (op_q == OP_LGET) && (cnt_q != '0);
  assign d_lset    = (op_q == OP_LSET) || (op_q == OP_LTEE);
  assign dec_get   = d_ret_get || d_lg_get;

  always_comb begin
    pre_err  = E_OK;
    pre_nops = '0;
    case (cmd_op)
      OP_CALL: begin
        pre_nops = {1'b0, cmd_nlocals};
        if (depth_q == FW'(FRAMES))
          pre_err = E_FOVF;
        else if (cmd_arg > avail)
          pre_err = E_AR;
        else if (({1'b0, st_index} + {1'b0, cmd_nlocals})
                 > {1'b0, MAX_STACK})
          pre_err = E_OVF;
      end
      OP_RET: begin
        pre_nops = {cmd_arg, 1'b1};
        if (depth_q == '0)
          pre_err = E_FUND;
        else if (cmd_arg > avail)
          pre_err = E_AR;
      end
      OP_LGET: begin
        pre_nops = CW'(2);
        if (cmd_arg >= nloc)
          pre_err = E_IDX;
        else if (st_index == MAX_STACK)
          pre_err = E_OVF;
      end
      OP_LSET, OP_LTEE: begin
        pre_nops = CW'(1);
        if (cmd_arg >= nloc)
          pre_err = E_IDX;
        else if (st_index == limit_q)
          pre_err = E_UND;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      limit_q  <= '0;
      depth_q  <= '0;
      op_q     <= '0;
      arg_q    <= '0;
      nl_q     <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      getter_q <= '0;
      rdata_q  <= '0;
      rerr_q   <= E_OK;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      limit_q  <= limit_d;
      depth_q  <= depth_d;
      op_q     <= op_d;
      arg_q    <= arg_d;
      nl_q     <= nl_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      getter_q <= getter_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_rec)
      rec_q[wr_ptr] <= {base_q, limit_q};
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    limit_d  = limit_q;
    depth_d  = depth_q;
    op_d     = op_q;
    arg_d    = arg_q;
    nl_d     = nl_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    getter_d = getter_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    push_rec = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      S_IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        arg_d   = cmd_arg;
        nl_d    = cmd_nlocals;
        idx_d   = st_index;
        cnt_d   = '0;
        last_d  = pre_nops - 1'b1;
        rdata_d = '0;
        rerr_d  = pre_err;
        if (pre_err != E_OK) begin
          state_d = S_RESP;
        end else if (pre_nops == '0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CHECK;
      S_CHECK: begin
        if (dec_get)
          getter_d = st_getter;
        if (st_error != 2'd0) begin
          rerr_d  = {1'b0, st_error};
          rdata_d = '0;
          state_d = S_RESP;
        end else if (is_last) begin
          commit  = 1'b1;
          state_d = S_RESP;
          if (op_q == OP_LGET)
            rdata_d = getter_q;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (commit && c_op == OP_CALL) begin
      push_rec = 1'b1;
      depth_d  = depth_q + 1'b1;
      base_d   = c_idx - c_n;
      limit_d  = c_idx + c_l;
    end else if (commit && c_op == OP_RET) begin
      depth_d           = depth_q - 1'b1;
      {base_d, limit_d} = rec_q[rd_ptr];
    end
  end

  always_comb begin
    st_op          = ST_NONE;
    st_data        = '0;
    st_offset      = '0;
    st_lower_limit = '0;
    st_upper_limit = '0;
    st_dropTos     = 1'b0;
    if (state_q == S_ISSUE) begin
      unique case (1'b1)
        d_call: st_op = ST_PUSH;
        d_ret_get: begin
          st_op          = ST_UGET;
          st_lower_limit = idx_q - arg_q;
          st_upper_limit = idx_q;
          st_offset      = half;
        end
        d_ret_set: begin
          st_op          = ST_USET;
          st_data        = getter_q;
          st_lower_limit = base_q;
          st_upper_limit = idx_q;
          st_offset      = half;
        end
        d_ret_ir: begin
          st_op     = ST_IRST;
          st_offset = base_q + arg_q;
        end
        d_lg_get: begin
          st_op          = ST_UGET;
          st_lower_limit = base_q;
          st_upper_limit = limit_q;
          st_offset      = arg_q;
        end
        d_lg_push: begin
          st_op   = ST_PUSH;
          st_data = getter_q;
        end
        d_lset: begin
          st_op          = ST_USET;
          st_data        = st_out;
          st_lower_limit = base_q;
          st_upper_limit = limit_q;
          st_offset      = arg_q;
          st_dropTos     = (op_q == OP_LSET);
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready          = (state_q == S_IDLE);
  assign rsp_valid          = (state_q == S_RESP);
  assign rsp_data           = rdata_q;
  assign rsp_error          = rerr_q;
  assign st_underflow_limit = limit_q;

endmodule

// File: tb/tb_wasm_frame_ctrl.sv
// tb_wasm_frame_ctrl: directed bench with a small SuperStack model and a
// queue-based scoreboard checking response code, data and latency.
module tb_wasm_frame_ctrl;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 3;
  localparam int FRAMES = 8;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [DEPTH:0]   cmd_arg;
  logic [DEPTH:0]   cmd_nlocals;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [2:0]       rsp_error;
  logic [2:0]       st_op;
  logic [WIDTH-1:0] st_data;
  logic [DEPTH:0]   st_offset;
  logic [DEPTH:0]   st_lower_limit;
  logic [DEPTH:0]   st_upper_limit;
  logic [DEPTH:0]   st_underflow_limit;
  logic             st_dropTos;
  logic [DEPTH:0]   st_index;
  logic [WIDTH-1:0] st_out;
  logic [WIDTH-1:0] st_getter;
  logic [1:0]       st_error;

  wasm_frame_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_nlocals(cmd_nlocals),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_error(rsp_error),
    .st_op(st_op), .st_data(st_data),
    .st_offset(st_offset),
    .st_lower_limit(st_lower_limit),
    .st_upper_limit(st_upper_limit),
    .st_underflow_limit(st_underflow_limit),
    .st_dropTos(st_dropTos),
    .st_index(st_index), .st_out(st_out),
    .st_getter(st_getter), .st_error(st_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SuperStack model
  logic [WIDTH-1:0] mem [16];
  logic [3:0]       sidx;
  logic [1:0]       serr = 2'd0;
  logic [WIDTH-1:0] sget = '0;
  logic             tb_clr, tb_push;
  logic [WIDTH-1:0] tb_val;
  int               ops_cnt = 0;

  assign st_index  = sidx;
  assign st_out    = mem[sidx - 4'd1];
  assign st_getter = sget;
  assign st_error  = serr;

  always @(posedge clk) begin
    logic [4:0] ea;
    ea = {1'b0, st_lower_limit} + {1'b0, st_offset};
    serr <= 2'd0;
    if (st_op != 3'd0) ops_cnt <= ops_cnt + 1;
    if (tb_clr) begin
      sidx <= '0;
    end else if (tb_push) begin
      mem[sidx] <= tb_val;
      sidx <= sidx + 4'd1;
    end else begin
      case (st_op)
        3'd1: if (sidx == 4'd15) serr <= 2'd2;
              else begin
                mem[sidx] <= st_data;
                sidx <= sidx + 4'd1;
              end
        3'd2: if (sidx == 4'd0) serr <= 2'd1;
              else sidx <= sidx - 4'd1;
        3'd3: mem[sidx - 4'd1] <= st_data;
        3'd4: sidx <= st_offset;
        3'd6: if (ea >= {1'b0, st_upper_limit}) serr <= 2'd3;
              else sget <= mem[ea[3:0]];
        3'd7: if (ea >= {1'b0, st_upper_limit}) serr <= 2'd3;
              else begin
                mem[ea[3:0]] <= st_data;
                if (st_dropTos) sidx <= sidx - 4'd1;
              end
        default: ;
      endcase
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    string      nm;
    logic [2:0] err;
    logic [7:0] data;
    int         lat;
    int         acc;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: samples just after the falling edge, once the bench's
  // inputs for the coming rising edge are settled.
  bit first_seen = 1'b0;
  int first_cyc  = 0;
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      first_seen = 1'b0;
    end else if (rsp_valid) begin
      if (!first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk({e.nm, "_err"}, rsp_error, e.err);
          chk({e.nm, "_data"}, rsp_data, e.data);
          chk({e.nm, "_lat"}, first_cyc - e.acc, e.lat);
        end
        first_seen = 1'b0;
      end
    end
  end

  task automatic send(input string nm, input logic [2:0] op,
                      input logic [3:0] arg, input logic [3:0] nl,
                      input logic [2:0] err, input logic [7:0] data,
                      input int lat);
    exp_t e;
    int k;
    k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) chk({nm, "_ready_to"}, cmd_ready, 1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_arg     = arg;
    cmd_nlocals = nl;
    e.nm = nm; e.err = err; e.data = data;
    e.lat = lat; e.acc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid   = 1'b0;
    cmd_op      = 3'd0;
    cmd_arg     = '0;
    cmd_nlocals = '0;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic run(input string nm, input logic [2:0] op,
                     input logic [3:0] arg, input logic [3:0] nl,
                     input logic [2:0] err, input logic [7:0] data,
                     input int lat);
    send(nm, op, arg, nl, err, data, lat);
    drain(nm);
  endtask

  task automatic push_val(input logic [7:0] v);
    tb_push = 1'b1;
    tb_val  = v;
    @(negedge clk);
    tb_push = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ops0;
    int k;
    reset       = 1'b1;
    tb_clr      = 1'b1;
    tb_push     = 1'b0;
    tb_val      = '0;
    cmd_valid   = 1'b0;
    cmd_op      = 3'd0;
    cmd_arg     = '0;
    cmd_nlocals = '0;
    rsp_ready   = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    tb_clr = 1'b0;

    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_st_op", st_op, 0);
    chk("rst_dropTos", st_dropTos, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_uf_limit", st_underflow_limit, 0);

    ops0 = ops_cnt;
    run("lget_empty", 3'd3, 4'd0, 4'd0, 3'd3, 8'd0, 1);
    chk("lget_empty_noops", ops_cnt - ops0, 0);

    push_val(8'd5);
    push_val(8'd6);
    run("call_2_1", 3'd1, 4'd2, 4'd1, 3'd0, 8'd0, 3);
    chk("call_index", sidx, 3);
    chk("call_uflim", st_underflow_limit, 3);
    chk("call_zero_local", mem[2], 0);

    run("lset_under", 3'd4, 4'd0, 4'd0, 3'd1, 8'd0, 1);
    run("call_ovf", 3'd1, 4'd0, 4'd15, 3'd2, 8'd0, 1);

    run("lget_1", 3'd3, 4'd1, 4'd0, 3'd0, 8'd6, 5);
    chk("lget_index", sidx, 4);
    chk("lget_pushed", mem[3], 6);

    run("lset_2", 3'd4, 4'd2, 4'd0, 3'd0, 8'd0, 3);
    chk("lset_slot2", mem[2], 6);
    chk("lset_index", sidx, 3);

    run("lget_badidx", 3'd3, 4'd3, 4'd0, 3'd3, 8'd0, 1);
    run("ret_arity", 3'd2, 4'd5, 4'd0, 3'd6, 8'd0, 1);

    push_val(8'd9);
    run("ret_1", 3'd2, 4'd1, 4'd0, 3'd0, 8'd0, 7);
    chk("ret_slot0", mem[0], 9);
    chk("ret_index", sidx, 1);
    chk("ret_uflim", st_underflow_limit, 0);

    for (int i = 0; i < FRAMES; i++)
      run("nest_call", 3'd1, 4'd0, 4'd0, 3'd0, 8'd0, 1);
    run("nest_fovf", 3'd1, 4'd0, 4'd0, 3'd4, 8'd0, 1);
    chk("nest_uflim", st_underflow_limit, 1);
    for (int i = 0; i < FRAMES; i++)
      run("nest_ret", 3'd2, 4'd0, 4'd0, 3'd0, 8'd0, 3);
    chk("nest_index", sidx, 1);
    run("ret_fund", 3'd2, 4'd0, 4'd0, 3'd5, 8'd0, 1);

    run("call_1_0", 3'd1, 4'd1, 4'd0, 3'd0, 8'd0, 1);
    rsp_ready = 1'b0;
    send("lget_hold", 3'd3, 4'd0, 4'd0, 3'd0, 8'd9, 5);
    k = 0;
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("hold_rsp_seen", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, 9);
      chk("hold_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    drain("lget_hold");
    chk("hold_index", sidx, 2);

    send("ret_abort", 3'd2, 4'd1, 4'd0, 3'd0, 8'd0, 7);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_st_op", st_op, 0);
    chk("abort_uflim", st_underflow_limit, 0);
    run("abort_depth0", 3'd2, 4'd0, 4'd0, 3'd5, 8'd0, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
